fetch_imem_responder: RTL

//  Receive end of the fetch_out bus (pc, npc, Imem_rd) from the LC3 Fetch stage.

---
 rtl/fetch_imem_responder_if.sv | 32 +++
 rtl/fetch_imem_responder.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/fetch_imem_responder_if.sv
// rtl/fetch_imem_responder_if.sv - fetch_out bus, imem port and decode handshake bundle
interface fetch_imem_responder_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] npc;
    logic              Imem_rd;
    logic              flush;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_en;
    logic [DATA_W-1:0] imem_dout;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic [ADDR_W-1:0] instr_npc;
    logic              fetch_stall;
    logic              npc_err;

    modport slave (
        input  pc, npc, Imem_rd, flush, imem_dout, instr_ready,
        output imem_addr, imem_en, instr_valid, instr, instr_pc, instr_npc,
               fetch_stall, npc_err
    );

    modport master (
        output pc, npc, Imem_rd, flush, imem_dout, instr_ready,
        input  imem_addr, imem_en, instr_valid, instr, instr_pc, instr_npc,
               fetch_stall, npc_err
    );
endinterface

// File: rtl/fetch_imem_responder.sv
// rtl/fetch_imem_responder.sv - imem read issue, in-flight pipe and show-ahead decode buffer
module fetch_imem_responder #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    fetch_imem_responder_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [RD_LAT-1:0] pipe_v_q, pipe_v_d;
    logic [ADDR_W-1:0] pipe_pc_q  [RD_LAT];
    logic [ADDR_W-1:0] pipe_pc_d  [RD_LAT];
    logic [ADDR_W-1:0] pipe_npc_q [RD_LAT];
    logic [ADDR_W-1:0] pipe_npc_d [RD_LAT];

    logic [DATA_W-1:0] fifo_instr_q [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_instr_d [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_q    [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_pc_d    [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_npc_q   [FIFO_DEPTH];
    logic [ADDR_W-1:0] fifo_npc_d   [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic              npc_err_q, npc_err_d;

    logic [CNT_W-1:0]  inflight_cnt;
    logic [CNT_W:0]    credit_used;
    logic              issue;
    logic              ret;
    logic              pop;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight_cnt = inflight_cnt + CNT_W'(pipe_v_q[i]);
        end
    end

    // Stall comes only from registered counts, so a same-cycle pop never frees a slot early.
    assign credit_used     = {1'b0, fifo_cnt_q} + {1'b0, inflight_cnt};
    assign bus.fetch_stall = credit_used >= (CNT_W + 1)'(FIFO_DEPTH);
    assign issue           = bus.Imem_rd & ~bus.fetch_stall & ~bus.flush & reset;
    assign bus.imem_en     = issue;
    assign bus.imem_addr   = bus.pc;
    assign ret             = pipe_v_q[RD_LAT-1] & ~bus.flush;
    assign bus.instr_valid = fifo_cnt_q != '0;
    assign pop             = bus.instr_valid & bus.instr_ready;
    assign bus.instr       = bus.instr_valid ? fifo_instr_q[rd_ptr_q] : '0;
    assign bus.instr_pc    = bus.instr_valid ? fifo_pc_q[rd_ptr_q]    : '0;
    assign bus.instr_npc   = bus.instr_valid ? fifo_npc_q[rd_ptr_q]   : '0;
    assign bus.npc_err     = npc_err_q;

    always_comb begin
        pipe_v_d      = '0;
        pipe_pc_d     = pipe_pc_q;
        pipe_npc_d    = pipe_npc_q;
        pipe_v_d[0]   = issue;
        pipe_pc_d[0]  = bus.pc;
        pipe_npc_d[0] = bus.npc;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_v_d[i]   = pipe_v_q[i-1];
            pipe_pc_d[i]  = pipe_pc_q[i-1];
            pipe_npc_d[i] = pipe_npc_q[i-1];
        end
        if (bus.flush) begin
            pipe_v_d = '0;
        end
    end

    always_comb begin
        fifo_instr_d = fifo_instr_q;
        fifo_pc_d    = fifo_pc_q;
        fifo_npc_d   = fifo_npc_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        fifo_cnt_d   = fifo_cnt_q;
        if (ret) begin
            fifo_instr_d[wr_ptr_q] = bus.imem_dout;
            fifo_pc_d[wr_ptr_q]    = pipe_pc_q[RD_LAT-1];
            fifo_npc_d[wr_ptr_q]   = pipe_npc_q[RD_LAT-1];
            wr_ptr_d               = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({ret, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
        if (bus.flush) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            fifo_cnt_d = '0;
        end
    end

    always_comb begin
        npc_err_d = npc_err_q;
        if (issue && (bus.npc != bus.pc + ADDR_W'(1))) begin
            npc_err_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pipe_v_q   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            npc_err_q  <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_pc_q[i]  <= '0;
                pipe_npc_q[i] <= '0;
            end
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_instr_q[i] <= '0;
                fifo_pc_q[i]    <= '0;
                fifo_npc_q[i]   <= '0;
            end
        end else begin
            pipe_v_q     <= pipe_v_d;
            pipe_pc_q    <= pipe_pc_d;
            pipe_npc_q   <= pipe_npc_d;
            fifo_instr_q <= fifo_instr_d;
            fifo_pc_q    <= fifo_pc_d;
            fifo_npc_q   <= fifo_npc_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            fifo_cnt_q   <= fifo_cnt_d;
            npc_err_q    <= npc_err_d;
        end
    end
endmodule
